// File: rtl/load_store_unit.sv
// ============================================================================
// load_store_unit : RV32I execute-stage load/store unit (req/gnt/rvalid port)
// Optional: LSU_MISALIGN_TRAP_EN traps misaligned accesses. Rev 1.0
// ============================================================================
`default_nettype none

module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [6:0]  opcode,
  input  logic [2:0]  func3,
  input  logic [31:0] alu_out,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_in,
  output logic        dmem_req,
  input  logic        dmem_gnt,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic        misalign,
`endif
  output logic        mem_done
);

  localparam logic [6:0] OP_L = 7'b0000011;
  localparam logic [6:0] OP_S = 7'b0100011;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2} state_t;

  state_t      state_q;
  logic        req_q, we_q, wb_valid_q, done_q;
  logic [3:0]  be_q;
  logic [29:0] addr_q;
  logic [31:0] wdata_q, wb_data_q;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic [4:0]  rd_q, wb_rd_q;

  logic        ld_ok, st_ok, trap;
  logic [31:0] addr_f, wdata_d, ld_ext;
  logic [3:0]  be_d;
  logic [7:0]  byte_w;
  logic [15:0] half_w;

  // Decode, forced natural alignment and store lane generation
  always_comb begin
    ld_ok = (opcode == OP_L) && (func3 == 3'b000 || func3 == 3'b001 || func3 == 3'b010 ||
                                 func3 == 3'b100 || func3 == 3'b101);
    st_ok = (opcode == OP_S) && (func3 == 3'b000 || func3 == 3'b001 || func3 == 3'b010);
    case (func3[1:0])
      2'b01:   addr_f = {alu_out[31:1], 1'b0};
      2'b10:   addr_f = {alu_out[31:2], 2'b00};
      default: addr_f = alu_out;
    endcase
    be_d    = 4'b1111;
    wdata_d = 32'h0;
    if (st_ok) begin
      case (func3[1:0])
        2'b00: begin
          be_d    = 4'b0001 << addr_f[1:0];
          wdata_d = {4{store_data[7:0]}};
        end
        2'b01: begin
          be_d    = addr_f[1] ? 4'b1100 : 4'b0011;
          wdata_d = {2{store_data[15:0]}};
        end
        default: begin
          be_d    = 4'b1111;
          wdata_d = store_data;
        end
      endcase
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = (func3[1:0] == 2'b01 && alu_out[0]) ||
                (func3[1:0] == 2'b10 && alu_out[1:0] != 2'b00);
`else
  assign trap = 1'b0;
`endif

  // Load lane extraction and extension
  always_comb begin
    case (lane_q)
      2'd0:    byte_w = dmem_rdata[7:0];
      2'd1:    byte_w = dmem_rdata[15:8];
      2'd2:    byte_w = dmem_rdata[23:16];
      default: byte_w = dmem_rdata[31:24];
    endcase
    half_w = lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (f3_q[1:0])
      2'b00:   ld_ext = {{24{~f3_q[2] & byte_w[7]}}, byte_w};
      2'b01:   ld_ext = {{16{~f3_q[2] & half_w[15]}}, half_w};
      default: ld_ext = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      be_q       <= 4'h0;
      addr_q     <= 30'h0;
      wdata_q    <= 32'h0;
      f3_q       <= 3'h0;
      lane_q     <= 2'h0;
      rd_q       <= 5'h0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= 5'h0;
      wb_data_q  <= 32'h0;
      done_q     <= 1'b0;
    end else begin
      wb_valid_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (ex_valid && (ld_ok || st_ok) && !trap) begin
            we_q    <= st_ok;
            be_q    <= be_d;
            addr_q  <= addr_f[31:2];
            wdata_q <= wdata_d;
            f3_q    <= func3;
            lane_q  <= addr_f[1:0];
            rd_q    <= rd_in;
            req_q   <= 1'b1;
            state_q <= S_REQ;
          end
        end
        S_REQ: begin
          if (dmem_gnt) begin
            req_q <= 1'b0;
            if (we_q) begin
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (dmem_rvalid) begin
            wb_data_q  <= ld_ext;
            wb_rd_q    <= rd_q;
            wb_valid_q <= 1'b1;
            done_q     <= 1'b1;
            state_q    <= S_IDLE;
          end
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic mis_q;
  always_ff @(posedge clk) begin
    if (rst) mis_q <= 1'b0;
    else     mis_q <= (state_q == S_IDLE) && ex_valid && (ld_ok || st_ok) && trap;
  end
  assign misalign = mis_q;
`endif

  assign ex_ready   = (state_q == S_IDLE);
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_be    = be_q;
  assign dmem_addr  = {addr_q, 2'b00};
  assign dmem_wdata = wdata_q;
  assign wb_valid   = wb_valid_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign mem_done   = done_q;

endmodule

`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Execute-stage memory unit that sits directly downstream of the ALU in the RV32I core. It consumes the ALU's effective-address result for OP_L/OP_S instructions and runs a request/grant/response transaction on the data-memory port. For stores it generates byte enables and lane-replicated write data; for loads it extracts and sign- or zero-extends the returned data. Its completion handshake stalls the pipeline while a transaction is outstanding.

## Interface
- No parameters; all datapaths are fixed at 32 bits.
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- ex_valid  in  1  an instruction is presented on opcode/func3/alu_out/store_data/rd_in
- ex_ready  out  1  unit is idle and accepts; accept = ex_valid & ex_ready
- opcode  in  7  instruction opcode; OP_L = 7'b0000011, OP_S = 7'b0100011
- func3  in  3  LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010
- alu_out  in  32  effective byte address from the ALU
- store_data  in  32  rs2 value for stores
- rd_in  in  5  destination register for loads
- dmem_req  out  1  memory request valid
- dmem_gnt  in  1  memory accepted the request this cycle
- dmem_we  out  1  1 = write
- dmem_be  out  4  byte enables; bit n covers wdata[8n+7:8n]
- dmem_addr  out  32  word-aligned address, bits [1:0] = 0
- dmem_wdata  out  32  lane-replicated store data
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  32  read data word
- wb_valid  out  1  one-cycle pulse: wb_data/wb_rd are valid load results
- wb_rd  out  5  load destination register
- wb_data  out  32  extended load value
- mem_done  out  1  one-cycle pulse when any load or store completes
- misalign  out  1  one-cycle misaligned-access pulse; present only with LSU_MISALIGN_TRAP_EN

## Operation
- States: IDLE, REQ, WAIT.
  - ex_ready = (state == IDLE).
- IDLE, accept of a legal load or store:
  - Latch we, be, the aligned address, wdata, func3, addr[1:0] and rd_in.
  - Go to REQ.
- IDLE, accept of any other opcode, or an illegal func3:
  - Consumed and ignored.
  - Stay in IDLE; no request, wb_valid and mem_done stay 0.
- REQ:
  - dmem_req = 1; addr, we, be and wdata are held stable until dmem_gnt.
  - Grant on a store: pulse mem_done next cycle, go to IDLE.
  - Grant on a load: go to WAIT.
- WAIT:
  - dmem_req = 0.
  - On dmem_rvalid: register wb_data and wb_rd, pulse wb_valid and mem_done next cycle, go to IDLE.
- Store lanes:
  - SB: be = 4'b0001 << addr[1:0], wdata = {4{store_data[7:0]}}.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{store_data[15:0]}}.
  - SW: be = 4'b1111, wdata = store_data.
- Load extract:
  - LB/LBU: byte lane addr[1:0], sign-extended for LB, zero-extended for LBU.
  - LH/LHU: halfword lane addr[1], sign-extended for LH, zero-extended for LHU.
  - LW: whole word.
- Loads always drive dmem_be = 4'b1111, dmem_we = 0, dmem_wdata = 0.
- Ignored inputs:
  - dmem_gnt outside REQ.
  - dmem_rvalid outside WAIT.
  - ex_valid while not IDLE; upstream must hold the instruction until it is accepted.
- wb_rd = 0 is still reported with wb_valid = 1; the register file discards it.

## Timing
- Reset (rst = 1 at an edge):
  - State goes to IDLE and any outstanding transaction is dropped.
  - dmem_req, dmem_we, wb_valid, mem_done and misalign are 0.
  - dmem_be, dmem_addr, dmem_wdata, wb_rd and wb_data are 0; ex_ready is 1.
- Reset mid-operation: a later dmem_rvalid belonging to the dropped transaction is ignored.
- Cycle counts, with accept in cycle 0:
  - dmem_req is high from cycle 1; earliest grant is cycle 1.
  - Store, zero wait: mem_done in cycle 2, ex_ready high in cycle 2.
  - Load, zero wait, rvalid in cycle 2: wb_valid in cycle 3.
- Each grant wait cycle and each rvalid wait cycle adds one cycle.
- wb_valid, mem_done and misalign are registered and last exactly one cycle.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - Misaligned means a halfword with addr[0] = 1, or a word with addr[1:0] != 0.
  - A misaligned access makes no memory request and stays in IDLE.
  - misalign pulses in cycle 1; wb_valid and mem_done stay 0.
- LSU_MISALIGN_TRAP_EN undefined:
  - No misalign port.
  - Misaligned accesses are forced to natural alignment: addr[0] is cleared for halfwords, addr[1:0] for words.
  - Lane selection and byte enables use the forced address; the access proceeds normally.

## Test plan
- LW: alu_out 0x100, rd_in 5, gnt in cycle 1, rvalid in cycle 2 with rdata 0xDEADBEEF -> dmem_addr 0x100, be 1111, wb_valid in cycle 3, wb_rd 5, wb_data 0xDEADBEEF.
- LB and LBU: alu_out 0x103, rdata 0x80FF_FF00 -> LB gives wb_data 0xFFFFFF80; LBU gives 0x00000080.
- SH: alu_out 0x202, store_data 0x1234ABCD -> dmem_addr 0x200, be 1100, wdata 0xABCDABCD, we 1; with gnt in cycle 1, mem_done in cycle 2 and wb_valid stays 0.
- Backpressure: gnt held low 3 cycles, then rvalid 2 cycles after grant; a second ex_valid is presented throughout -> request fields stable, ex_ready low until the wb_valid cycle, second op accepted only after that.
- Misaligned LW at 0x101 -> with the macro: misalign in cycle 1, no dmem_req. Without the macro: dmem_addr 0x100, normal load.
- rst asserted while in WAIT, then rvalid next cycle -> state is IDLE, wb_valid stays 0, ex_ready is 1.
